// File: rtl/instruction_loader.sv
// Streams 32-bit words into byte-wide instruction memory, little-endian from address 0.
// Latency: handshake, then 4 byte writes; next word_ready 5 cycles later. Backpressure: word_ready low outside ACCEPT.
module instruction_loader #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  word_valid,
   input  logic [31:0]           word_input,
   input  logic                  last_input,
   output logic                  word_ready,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_address_output,
   output logic [7:0]            mem_data_output,
   output logic [ADDR_WIDTH-2:0] num_instructions_output,
   output logic [63:0]           last_pc_output,
   output logic                  load_done,
   output logic                  overflow_error
);

   localparam int WIDX = ADDR_WIDTH - 2;
   localparam logic [ADDR_WIDTH-2:0] WORDS = {1'b1, {WIDX{1'b0}}};

   typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} state_t;

   state_t                state;
   logic [31:0]           word_q;
   logic                  last_q;
   logic [1:0]            k;
   logic [1:0]            k_nxt;
   logic [ADDR_WIDTH-2:0] count_inc;

   assign k_nxt     = k + 2'd1;
   assign count_inc = num_instructions_output + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state                   <= IDLE;
         word_q                  <= '0;
         last_q                  <= 1'b0;
         k                       <= 2'd0;
         word_ready              <= 1'b0;
         mem_write_enable        <= 1'b0;
         mem_address_output      <= '0;
         mem_data_output         <= '0;
         num_instructions_output <= '0;
         last_pc_output          <= '0;
         load_done               <= 1'b0;
         overflow_error          <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state                   <= ACCEPT;
                  word_ready              <= 1'b1;
                  num_instructions_output <= '0;
                  last_pc_output          <= '0;
                  load_done               <= 1'b0;
                  overflow_error          <= 1'b0;
               end
            end
            ACCEPT: begin
               // The first byte is presented straight away so memory samples it on the next edge.
               if (word_valid) begin
                  state              <= WRITE;
                  word_ready         <= 1'b0;
                  word_q             <= word_input;
                  last_q             <= last_input;
                  k                  <= 2'd0;
                  mem_write_enable   <= 1'b1;
                  mem_address_output <= {num_instructions_output[WIDX-1:0], 2'b00};
                  mem_data_output    <= word_input[7:0];
               end
            end
            WRITE: begin
               if (k != 2'd3) begin
                  k                  <= k_nxt;
                  mem_address_output <= {mem_address_output[ADDR_WIDTH-1:2], k_nxt};
                  mem_data_output    <= word_q[{k_nxt, 3'b000} +: 8];
               end else begin
                  k                       <= 2'd0;
                  mem_write_enable        <= 1'b0;
                  mem_address_output      <= '0;
                  mem_data_output         <= '0;
                  num_instructions_output <= count_inc;
                  if (last_q) begin
                     state          <= DONE;
                     load_done      <= 1'b1;
                     // Old count equals new count minus one.
                     last_pc_output <= 64'({num_instructions_output[WIDX-1:0], 2'b00});
                  end else if (count_inc == WORDS) begin
                     state          <= ERROR;
                     overflow_error <= 1'b1;
                  end else begin
                     state      <= ACCEPT;
                     word_ready <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
